code_conv_scheduler: RTL
========================

Name: code_conv_scheduler

Overview:
- Shares one registered Gray/binary code-conversion datapath between NUM_REQ requesters.
- Uses round-robin arbitration and valid/ready handshakes on both the request and response sides.
- Each request carries a WIDTH-bit word and a mode bit: 0 = Gray-to-binary, 1 = binary-to-Gray.
- Sits between the requesting blocks and downstream consumers; the result is returned tagged with the requester index.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, code word width in bits (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester tag.
- CNT_W, 16, width of the completed-conversion counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_mode  in  NUM_REQ  per-requester mode (0 G->B, 1 B->G).
- req_data  in  NUM_REQ*WIDTH  packed words; requester i occupies [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- rsp_valid  out  1  result valid.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_mode  out  1  mode used for this result.
- rsp_data  out  WIDTH  converted word.
- rsp_ready  in  1  downstream accept.
- conv_count  out  CNT_W  completed conversions; saturating.
- busy  out  1  equals rsp_valid (output register occupied).

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_mode=0, rsp_data=0, conv_count=0, RR pointer last_grant=NUM_REQ-1. Requester 0 therefore has highest priority first.
- FSM with two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) | rsp_ready.
- Arbitration (combinational):
  - Search req_valid starting at (last_grant+1) mod NUM_REQ, wrapping.
  - The first set bit wins: grant_idx.
  - req_ready[grant_idx] = can_accept & any(req_valid); all other bits 0.
  - req_ready is 0 for a requester whose req_valid is low.
- Accept event: acc = |(req_valid & req_ready). On acc, at the next clk edge:
  - rsp_data <= conv(req_data[grant_idx], req_mode[grant_idx]).
  - rsp_id <= grant_idx; rsp_mode <= req_mode[grant_idx].
  - last_grant <= grant_idx.
  - state <= FULL.
- Latency: exactly 1 cycle from the accept edge to rsp_valid.
- Conversion rules:
  - G->B: B[W-1]=G[W-1]; B[i]=B[i+1]^G[i].
  - B->G: G = B ^ (B>>1).
- Response handshake:
  - Transfer occurs when rsp_valid & rsp_ready.
  - On transfer without acc: state <= EMPTY. rsp_data/rsp_id/rsp_mode keep their last values.
  - On transfer with acc in the same cycle: the output register reloads with the new result and stays FULL. This gives back-to-back throughput of one result per cycle.
- Backpressure: while FULL and rsp_ready=0, all req_ready=0 and rsp_* hold stable. last_grant does not move.
- conv_count increments by 1 on each response transfer and saturates at 2^CNT_W-1.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NUM_REQ-1,0,...
- A single requester held valid is granted every cycle.
- Requesters may deassert req_valid before being granted. No state is kept for un-granted requests.
- rst asserted mid-operation: the next edge forces all reset values. Any pending result is discarded and not counted. req_ready=0 during the rst cycle.
- No X propagation from req_data of non-granted requesters to any output.

Test Plan:
- Reset check: hold rst 2 cycles with all req_valid=1 -> req_ready=0 during rst. After rst release: rsp_valid=0, conv_count=0, and the first grant goes to requester 0.
- Gray->binary: req 2 sends data=4'b1011, mode=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=2, rsp_data=4'b1101. Sweep all 16 codes for 4'b0000..4'b1111 -> binary matches expected; conv_count=16.
- Binary->Gray: req 1 sends data=4'b0110, mode=1 -> rsp_data=4'b0101, rsp_mode=1, rsp_id=1.
- Round robin: all four valid continuously, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles; conv_count=8.
- Backpressure: one result FULL, rsp_ready=0 for 5 cycles while req 3 is valid -> req_ready=0 and rsp_* stable. When rsp_ready=1: transfer, req 3 accepted in the same cycle, and its result appears the next cycle.
- Mid-operation reset: rsp_valid=1, rsp_ready=0, assert rst one cycle -> rsp_valid=0, conv_count unchanged from reset (0), last_grant restored so requester 0 wins next.

Source files
------------

// File: rtl/code_conv_scheduler.sv
// Round-robin scheduler sharing one registered Gray<->binary converter between
// NUM_REQ requesters; results are returned tagged with the owning requester index.
module code_conv_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_mode,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_mode,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_ready,
  output logic [CNT_W-1:0]         conv_count,
  output logic                     busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready may depend on valid, valid never depends on ready.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant, grant_idx;
  logic              any_valid, can_accept, acc, xfer;
  logic              sel_mode;
  logic [WIDTH-1:0]  sel_data;

  function automatic logic [WIDTH-1:0] conv(input logic [WIDTH-1:0] d, input logic mode);
    logic [WIDTH-1:0] b;
    b = d ^ (d >> 1);
    if (!mode) begin
      b[WIDTH-1] = d[WIDTH-1];
      for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ d[i];
    end
    return b;
  endfunction

  assign any_valid  = |req_valid;
  assign can_accept = (state_q == EMPTY) | rsp_ready;
  assign acc        = |(req_valid & req_ready);
  assign xfer       = rsp_valid & rsp_ready;

  // Search starts just after the last winner and wraps around once.
  always_comb begin
    logic        found;
    int          idx;
    logic [ID_W-1:0] idx_w;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(last_grant) + k) % NUM_REQ;
      idx_w = ID_W'(idx);
      if (!found && req_valid[idx_w]) begin
        grant_idx = idx_w;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (can_accept && any_valid && !rst) req_ready[grant_idx] = 1'b1;
  end

  // Only the granted word reaches the converter, so other lanes cannot leak X.
  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_mode = req_mode[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (acc)       state_d = FULL;
    else if (xfer) state_d = EMPTY;
  end

  always_comb begin
    rsp_valid = (state_q == FULL);
    busy      = (state_q == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_mode   <= 1'b0;
      last_grant <= ID_W'(NUM_REQ-1);
    end else if (acc) begin
      rsp_data   <= conv(sel_data, sel_mode);
      rsp_id     <= grant_idx;
      rsp_mode   <= sel_mode;
      last_grant <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        conv_count <= '0;
    else if (xfer && !(&conv_count)) conv_count <= conv_count + 1'b1;
  end

endmodule
